// File: rtl/pc_sequencer_if.sv
// Decode-to-sequencer bus for pc_sequencer. The wrap signal exists only when
// PC_WRAP_DETECT_EN is defined.
interface pc_sequencer_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int STACK_DEPTH   = 4
);
  localparam int LW = $clog2(STACK_DEPTH + 1);

  logic                     enable;
  logic [2:0]               op;
  logic [ADDRESS_WIDTH-1:0] target;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [LW-1:0]            stack_level;
  logic                     stack_full;
  logic                     stack_empty;
  logic                     fault;
`ifdef PC_WRAP_DETECT_EN
  logic                     wrap;

  modport master (output enable, op, target, offset,
                  input  pc, stack_level, stack_full, stack_empty, fault, wrap);
  modport slave  (input  enable, op, target, offset,
                  output pc, stack_level, stack_full, stack_empty, fault, wrap);
`else
  modport master (output enable, op, target, offset,
                  input  pc, stack_level, stack_full, stack_empty, fault);
  modport slave  (input  enable, op, target, offset,
                  output pc, stack_level, stack_full, stack_empty, fault);
`endif
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: inc / jump / relative branch / call-return with a
// return-address stack. Optional wrap pulse under PC_WRAP_DETECT_EN.
module pc_sequencer #(
  parameter int                       ADDRESS_WIDTH = 8,
  parameter int                       STACK_DEPTH   = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0
) (
  input logic            clock,
  input logic            reset,
  pc_sequencer_if.slave  bus
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int LW = $clog2(STACK_DEPTH + 1);

  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;

  logic [AW-1:0] pc_q;
  logic [AW-1:0] stack_q [STACK_DEPTH];
  logic [LW-1:0] level_q;
  logic          fault_q;
  logic [AW-1:0] pc_inc, top;
  logic [AW:0]   br_sum;
  logic          full, empty;

  always_comb begin
    pc_inc = pc_q + 1'b1;
    br_sum = {1'b0, pc_q} + {1'b0, bus.offset};
    full   = (level_q == LW'(STACK_DEPTH));
    empty  = (level_q == '0);
    top    = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (level_q == LW'(i + 1)) top = stack_q[i];
  end

`ifdef PC_WRAP_DETECT_EN
  logic wrap_q;
  // Carry out of the unsigned add disagrees with the offset sign exactly when
  // the signed result leaves [0, 2^AW): overflow forward or underflow backward.
  always_ff @(posedge clock or posedge reset)
    if (reset)
      wrap_q <= 1'b0;
    else if (bus.enable && bus.op == OP_INC)
      wrap_q <= &pc_q;
    else if (bus.enable && bus.op == OP_BRANCH)
      wrap_q <= br_sum[AW] ^ bus.offset[AW-1];
    else
      wrap_q <= 1'b0;
  assign bus.wrap = wrap_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      level_q <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (bus.enable) begin
      case (bus.op)
        OP_INC:    pc_q <= pc_inc;
        OP_JUMP:   pc_q <= bus.target;
        OP_BRANCH: pc_q <= br_sum[AW-1:0];
        OP_CALL:
          if (full) fault_q <= 1'b1;
          else begin
            for (int i = 0; i < STACK_DEPTH; i++)
              if (level_q == LW'(i)) stack_q[i] <= pc_inc;
            level_q <= level_q + LW'(1);
            pc_q    <= bus.target;
          end
        OP_RET:
          if (empty) fault_q <= 1'b1;
          else begin
            pc_q    <= top;
            level_q <= level_q - LW'(1);
          end
        default: ;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.stack_level = level_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (8-bit, depth 4); wrap checked only when
// PC_WRAP_DETECT_EN is defined.
module tb_pc_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pc_sequencer_if #(.ADDRESS_WIDTH(8), .STACK_DEPTH(4)) bus ();

  pc_sequencer #(.ADDRESS_WIDTH(8), .STACK_DEPTH(4), .RESET_VECTOR(8'h00)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] pc;
    logic [2:0] lvl;
    logic       fault;
    logic       wrap;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] m_stk [$];
  logic [7:0] m_pc;
  logic       m_fault;
  int         errs = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00;
    m_fault = 1'b0;
    m_stk.delete();
    sb.delete();
  endtask

  // Drive one op, predict its effect, then compare after the edge.
  task automatic step(input logic en, input logic [2:0] o,
                      input logic [7:0] t, input logic [7:0] off);
    exp_t e;
    int   r;
    bus.enable = en; bus.op = o; bus.target = t; bus.offset = off;
    e.wrap = 1'b0;
    if (en) begin
      case (o)
        3'd1: begin e.wrap = (m_pc == 8'hFF); m_pc = m_pc + 8'd1; end
        3'd2: m_pc = t;
        3'd3: begin
          r = int'(m_pc) + int'($signed(off));
          e.wrap = (r < 0) || (r > 255);
          m_pc = r[7:0];
        end
        3'd4: if (m_stk.size() == 4) m_fault = 1'b1;
              else begin m_stk.push_back(m_pc + 8'd1); m_pc = t; end
        3'd5: if (m_stk.size() == 0) m_fault = 1'b1;
              else m_pc = m_stk.pop_back();
        default: ;
      endcase
    end
    e.pc = m_pc; e.lvl = 3'(m_stk.size()); e.fault = m_fault;
    sb.push_back(e);
    @(posedge clock); #1;
    if (sb.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk("pc",    32'(bus.pc),          32'(e.pc));
      chk("level", 32'(bus.stack_level), 32'(e.lvl));
      chk("full",  32'(bus.stack_full),  32'(e.lvl == 3'd4));
      chk("empty", 32'(bus.stack_empty), 32'(e.lvl == 3'd0));
      chk("fault", 32'(bus.fault),       32'(e.fault));
`ifdef PC_WRAP_DETECT_EN
      chk("wrap",  32'(bus.wrap),        32'(e.wrap));
`endif
    end
  endtask

  // Async reset asserted between edges; outputs must respond before any clock.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_pc"},    32'(bus.pc),          32'h00);
    chk({tag, "_level"}, 32'(bus.stack_level), 32'h0);
    chk({tag, "_fault"}, 32'(bus.fault),       32'h0);
`ifdef PC_WRAP_DETECT_EN
    chk({tag, "_wrap"},  32'(bus.wrap),        32'h0);
`endif
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.enable = 1'b0; bus.op = 3'd0; bus.target = 8'h00; bus.offset = 8'h00;
    model_reset();
    async_reset("rst0");
    chk("rst0_empty", 32'(bus.stack_empty), 32'h1);
    chk("rst0_full",  32'(bus.stack_full),  32'h0);

    repeat (5) step(1'b1, 3'd1, 8'h00, 8'h00);

    step(1'b1, 3'd2, 8'h10, 8'h00);
    step(1'b1, 3'd3, 8'h00, 8'hFC);
    chk("branch_back", 32'(bus.pc), 32'h0C);
    step(1'b1, 3'd3, 8'h00, 8'h05);
    chk("branch_fwd", 32'(bus.pc), 32'h11);

    step(1'b1, 3'd2, 8'h20, 8'h00);
    step(1'b1, 3'd4, 8'h40, 8'h00);
    step(1'b1, 3'd4, 8'h80, 8'h00);
    step(1'b1, 3'd5, 8'h00, 8'h00);
    chk("ret1", 32'(bus.pc), 32'h41);
    step(1'b1, 3'd5, 8'h00, 8'h00);
    chk("ret2", 32'(bus.pc), 32'h21);

    for (int i = 1; i <= 4; i++) step(1'b1, 3'd4, 8'(i), 8'h00);
    step(1'b1, 3'd4, 8'h99, 8'h00);
    chk("overflow_pc", 32'(bus.pc), 32'h04);
    step(1'b1, 3'd6, 8'h55, 8'h00);
    step(1'b1, 3'd5, 8'h00, 8'h00);

    async_reset("rst1");
    step(1'b1, 3'd5, 8'h00, 8'h00);
    chk("underflow_fault", 32'(bus.fault), 32'h1);
    step(1'b1, 3'd2, 8'h44, 8'h00);
    step(1'b0, 3'd2, 8'h33, 8'h00);
    chk("disabled_hold", 32'(bus.pc), 32'h44);

    async_reset("rst2");
    step(1'b1, 3'd7, 8'h12, 8'h00);
    step(1'b1, 3'd6, 8'h12, 8'h00);
    step(1'b1, 3'd4, 8'h50, 8'h00);
    step(1'b1, 3'd4, 8'h60, 8'h00);
    async_reset("rst_mid");

    step(1'b1, 3'd2, 8'hFF, 8'h00);
    step(1'b1, 3'd1, 8'h00, 8'h00);
    chk("inc_wrap_pc", 32'(bus.pc), 32'h00);
    step(1'b1, 3'd0, 8'h00, 8'h00);
    step(1'b1, 3'd2, 8'h02, 8'h00);
    step(1'b1, 3'd3, 8'h00, 8'hFD);
    chk("branch_wrap_pc", 32'(bus.pc), 32'hFF);
    step(1'b0, 3'd1, 8'h00, 8'h00);
    step(1'b1, 3'd3, 8'h00, 8'h01);
    step(1'b1, 3'd3, 8'h00, 8'h00);

    for (int i = 0; i < 80; i++)
      step(($urandom_range(9) != 0), 3'($urandom_range(7)),
           8'($urandom), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
